// File: rtl/inst_fetch_bridge.sv
// Bridge between the IF stage fetch request and an SRAM-like instruction bus
// (req / addr_ok / data_ok). Keeps one transaction in flight and drops responses cancelled by a flush.
module inst_fetch_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_take,
    input  logic              flush,
    output logic              fetch_ok,
    output logic [DATA_W-1:0] fetch_inst,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state;
    logic   discard;

    // inst_addr doubles as the latched request address, so it cannot move before addr_ok.
    // fetch_inst is the return buffer; IF only ever sees registered values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            inst_req   <= 1'b0;
            inst_addr  <= '0;
            fetch_ok   <= 1'b0;
            fetch_inst <= '0;
            discard    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
            case (state)
                S_IDLE: begin
                    if (fetch_en && !flush) begin
                        inst_addr <= fetch_pc;
                        inst_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A request on the bus is never withdrawn; a flush only marks its reply as stale.
                    if (flush) discard <= 1'b1;
                    if (inst_addr_ok) begin
                        inst_req <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard || flush) begin
                            discard <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            fetch_inst <= inst_rdata;
                            fetch_ok   <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (fetch_take || flush) begin
                        fetch_ok <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus protocol checks: data only while a read is outstanding, address held until accepted.
    a_data_ok_in_wait : assert property (@(posedge clk) disable iff (reset)
        inst_data_ok |-> state == S_WAIT);
    a_addr_stable : assert property (@(posedge clk) disable iff (reset)
        inst_req && !inst_addr_ok |=> inst_addr == $past(inst_addr));

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: a scoreboard queue holds the words IF should see,
// and a monitor pops one entry each time fetch_ok rises.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        fetch_take;
    logic        flush;
    logic        fetch_ok;
    logic [31:0] fetch_inst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic        fetch_ok_q = 1'b0;

    inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .fetch_pc     (fetch_pc),
        .fetch_take   (fetch_take),
        .flush        (flush),
        .fetch_ok     (fetch_ok),
        .fetch_inst   (fetch_inst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each new fetch_ok pulse must deliver the oldest expected word.
    always @(negedge clk) begin
        if (!reset && fetch_ok && !fetch_ok_q) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got %h expected no word at %0t", fetch_inst, $time);
            end else begin
                check("sb_word", fetch_inst, exp_q.pop_front());
            end
        end
        fetch_ok_q = fetch_ok;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Minimum-latency fetch that IF takes immediately; starts and ends in IDLE.
    task automatic fetch_word(input string tag, input logic [31:0] pc, input logic [31:0] word);
        fetch_en = 1'b1;
        fetch_pc = pc;
        tick();
        check({tag, "_req"}, {31'd0, inst_req}, 32'd1);
        check({tag, "_addr"}, inst_addr, pc);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = word;
        exp_q.push_back(word);
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        check({tag, "_ok"}, {31'd0, fetch_ok}, 32'd1);
        fetch_take = 1'b1;
        tick();
        fetch_take = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        fetch_en     = 1'b0;
        fetch_pc     = '0;
        fetch_take   = 1'b0;
        flush        = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        #2;
        check("rst_req", {31'd0, inst_req}, 32'd0);
        check("rst_ok", {31'd0, fetch_ok}, 32'd0);
        check("rst_addr", inst_addr, 32'd0);
        check("rst_inst", fetch_inst, 32'd0);
        tick();
        reset = 1'b0;

        // Boot fetch at minimum latency, then IF stalls 5 cycles in HOLD.
        fetch_en = 1'b1;
        fetch_pc = 32'hbfc00000;
        tick();
        check("t1_req", {31'd0, inst_req}, 32'd1);
        check("t1_addr", inst_addr, 32'hbfc00000);
        check("t1_ok_early", {31'd0, fetch_ok}, 32'd0);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        check("t1_req_drop", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h3c080001;
        exp_q.push_back(32'h3c080001);
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        check("t1_ok_cycle3", {31'd0, fetch_ok}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_ok", {31'd0, fetch_ok}, 32'd1);
            check("t2_hold_req", {31'd0, inst_req}, 32'd0);
            check("t2_hold_inst", fetch_inst, 32'h3c080001);
        end
        fetch_take = 1'b1;
        fetch_pc   = 32'hbfc00004;
        tick();
        fetch_take = 1'b0;
        check("t2_take_ok", {31'd0, fetch_ok}, 32'd0);
        check("t2_take_idle", {31'd0, inst_req}, 32'd0);
        tick();
        check("t2_next_req", {31'd0, inst_req}, 32'd1);
        check("t2_next_addr", inst_addr, 32'hbfc00004);

        // addr_ok withheld 4 cycles while fetch_pc wanders.
        for (int i = 0; i < 4; i++) begin
            fetch_pc = 32'h8000_0000 + 32'(i * 16);
            tick();
            check("t3_req_held", {31'd0, inst_req}, 32'd1);
            check("t3_addr_held", inst_addr, 32'hbfc00004);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h24090002;
        exp_q.push_back(32'h24090002);
        tick();
        inst_data_ok = 1'b0;
        fetch_take   = 1'b1;
        tick();
        fetch_take = 1'b0;

        // Flush in WAIT; the stale reply arrives 2 cycles later and must be dropped.
        fetch_pc = 32'hbfc00008;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        flush        = 1'b1;
        fetch_pc     = 32'hbfc00380;
        tick();
        flush = 1'b0;
        check("t4_discard_set", {31'd0, dut.discard}, 32'd1);
        tick();
        check("t4_no_issue", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hdeadbeef;
        tick();
        inst_data_ok = 1'b0;
        check("t4_dropped_ok", {31'd0, fetch_ok}, 32'd0);
        check("t4_discard_clr", {31'd0, dut.discard}, 32'd0);
        fetch_word("t4_vec", 32'hbfc00380, 32'h3c1a0000);

        // flush and data_ok in the same WAIT cycle.
        fetch_pc = 32'hbfc0000c;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h11111111;
        flush        = 1'b1;
        tick();
        inst_data_ok = 1'b0;
        flush        = 1'b0;
        check("t5_ok", {31'd0, fetch_ok}, 32'd0);
        check("t5_req", {31'd0, inst_req}, 32'd0);
        check("t5_discard", {31'd0, dut.discard}, 32'd0);
        fetch_word("t5_after", 32'hbfc00380, 32'h22222222);

        // addr_ok and flush together in REQ: go to WAIT with discard set.
        fetch_pc = 32'hbfc00010;
        tick();
        inst_addr_ok = 1'b1;
        flush        = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        flush        = 1'b0;
        check("t5b_req", {31'd0, inst_req}, 32'd0);
        check("t5b_discard", {31'd0, dut.discard}, 32'd1);
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h33333333;
        tick();
        inst_data_ok = 1'b0;
        check("t5b_ok", {31'd0, fetch_ok}, 32'd0);

        // Flush while IF holds a word invalidates it.
        fetch_pc = 32'hbfc00014;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h44444444;
        exp_q.push_back(32'h44444444);
        tick();
        inst_data_ok = 1'b0;
        flush        = 1'b1;
        tick();
        flush = 1'b0;
        check("thf_ok", {31'd0, fetch_ok}, 32'd0);

        // Asynchronous reset in WAIT, then restart from IDLE.
        fetch_pc = 32'hbfc00018;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_req", {31'd0, inst_req}, 32'd0);
        check("t6_ok", {31'd0, fetch_ok}, 32'd0);
        check("t6_addr", inst_addr, 32'd0);
        #2;
        reset = 1'b0;
        fetch_word("t6_restart", 32'hbfc00000, 32'h55555555);
        fetch_en = 1'b0;
        tick();
        tick();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
